// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//   Pulls fixed-length bursts from an upstream first-word-fall-through FIFO.
//   It emits them as framed beats on a valid/ready stream. When the FIFO
//   holds fewer words than a full burst, a partial burst can be flushed after
//   an idle timeout.
//
// Ports
//   clk, rst       : clock (rising edge), asynchronous active-high reset
//   en             : allows new bursts to start (never aborts a running one)
//   fifo_dout      : FWFT head word
//   fifo_empty     : FIFO empty flag
//   fifo_rd_space  : FIFO fill level (registered, may lag, never overstated)
//   fifo_rd_en     : FIFO pop (combinational)
//   m_data/m_valid : registered output beat and its valid
//   m_ready        : downstream accept
//   m_sof/m_eof    : first / last beat of a burst
//   m_len          : length of the burst in flight, stable sof..eof
//   frame_cnt      : completed bursts, wraps at 2**16
//   busy           : state is not IDLE
//   dbg_state      : raw FSM state (0 IDLE, 1 BURST, 2 DRAIN)
//
// Handshake: a beat transfers on a rising edge where m_valid & m_ready.
// While m_valid & ~m_ready the beat (data, sof, eof) is held unchanged.
// m_valid never drops without a transfer.
module fifo_burst_reader #(
  parameter int DW        = 8,
  parameter int AW        = 8,
  parameter int BURST_LEN = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] fifo_dout,
  input  logic          fifo_empty,
  input  logic [AW:0]   fifo_rd_space,
  output logic          fifo_rd_en,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_sof,
  output logic          m_eof,
  output logic [AW:0]   m_len,
  output logic [15:0]   frame_cnt,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  if (BURST_LEN < 1 || BURST_LEN > (1 << AW)) begin : g_bad_burst_len
    $error("fifo_burst_reader: BURST_LEN must lie in 1..2**AW");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [AW:0] BURST_LEN_W = (AW+1)'(BURST_LEN);
  localparam logic [AW:0] ONE_W       = (AW+1)'(1);
  localparam logic [15:0] TIMEOUT_W   = 16'(TIMEOUT);

  state_t        state_q, state_d;
  logic [AW:0]   remaining_q, remaining_d;
  logic [AW:0]   m_len_q, m_len_d;
  logic [15:0]   idle_cnt_q, idle_cnt_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic          m_valid_q, m_valid_d;
  logic          m_sof_q, m_sof_d;
  logic          m_eof_q, m_eof_d;
  logic          pop;

  // Pop only when the output register is free or being emptied this cycle.
  assign pop = (state_q == BURST) && (remaining_q != '0) && !fifo_empty &&
               (!m_valid_q || m_ready);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    m_len_d     = m_len_q;
    idle_cnt_d  = '0;
    frame_cnt_d = frame_cnt_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    m_sof_d     = m_sof_q;
    m_eof_d     = m_eof_q;

    case (state_q)
      IDLE: begin
        if (en && (fifo_rd_space >= BURST_LEN_W)) begin
          state_d     = BURST;
          m_len_d     = BURST_LEN_W;
          remaining_d = BURST_LEN_W;
        end else if (en && !fifo_empty) begin
          if ((TIMEOUT != 0) && (idle_cnt_q == TIMEOUT_W)) begin
            if (fifo_rd_space != '0) begin
              state_d     = BURST;
              m_len_d     = fifo_rd_space;
              remaining_d = fifo_rd_space;
            end else begin
              // The fill level lags the empty flag; park at the threshold
              // until a non-zero level becomes visible.
              idle_cnt_d = idle_cnt_q;
            end
          end else begin
            idle_cnt_d = idle_cnt_q + 16'd1;
          end
        end
      end
      BURST: begin
        if (pop) begin
          remaining_d = remaining_q - ONE_W;
          if (remaining_q == ONE_W) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // The last beat sits in the output register; the burst completes
        // when it is accepted.
        if (m_valid_q && m_ready) begin
          state_d     = IDLE;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      m_data_d  = fifo_dout;
      m_valid_d = 1'b1;
      m_sof_d   = (remaining_q == m_len_q);
      m_eof_d   = (remaining_q == ONE_W);
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
      m_sof_d   = 1'b0;
      m_eof_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      m_len_q     <= '0;
      idle_cnt_q  <= '0;
      frame_cnt_q <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_sof_q     <= 1'b0;
      m_eof_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      m_len_q     <= m_len_d;
      idle_cnt_q  <= idle_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_sof_q     <= m_sof_d;
      m_eof_q     <= m_eof_d;
    end
  end

  assign fifo_rd_en = pop;
  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign m_sof      = m_sof_q;
  assign m_eof      = m_eof_q;
  assign m_len      = m_len_q;
  assign frame_cnt  = frame_cnt_q;
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader.
//   dut_a : BURST_LEN=4, TIMEOUT=5, fed by a small FWFT FIFO model
//   dut_b : BURST_LEN=1, TIMEOUT=255, fed by a small FWFT FIFO model
//   dut_c : BURST_LEN=4, TIMEOUT=0, fed by constant FIFO inputs
module tb_fifo_burst_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------- dut_a and its FIFO model ----------------
  logic       en_a, ready_a, hold_a, rd_en_a, empty_a;
  logic       m_valid_a, sof_a, eof_a, busy_a;
  logic [7:0] dout_a, data_a;
  logic [8:0] space_a, len_a;
  logic [15:0] fcnt_a;
  logic [1:0] st_a;
  logic [7:0] mem_a [0:255];
  int         wp_a, rp_a, wp_lag_a;

  // hold_a lets the bench make the FIFO look empty without draining it.
  assign empty_a = (wp_a == rp_a) || hold_a;
  assign dout_a  = mem_a[rp_a[7:0]];
  assign space_a = 9'(wp_lag_a - rp_a);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rp_a     <= 0;
      wp_lag_a <= 0;
    end else begin
      wp_lag_a <= wp_a;
      if (rd_en_a) rp_a <= rp_a + 1;
    end
  end

  fifo_burst_reader #(.DW(8), .AW(8), .BURST_LEN(4), .TIMEOUT(5)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .fifo_dout(dout_a), .fifo_empty(empty_a),
    .fifo_rd_space(space_a), .fifo_rd_en(rd_en_a), .m_data(data_a),
    .m_valid(m_valid_a), .m_ready(ready_a), .m_sof(sof_a), .m_eof(eof_a),
    .m_len(len_a), .frame_cnt(fcnt_a), .busy(busy_a), .dbg_state(st_a)
  );

  // ---------------- dut_b and its FIFO model ----------------
  logic       en_b, ready_b, rd_en_b, empty_b;
  logic       m_valid_b, sof_b, eof_b, busy_b;
  logic [7:0] dout_b, data_b;
  logic [8:0] space_b, len_b;
  logic [15:0] fcnt_b;
  logic [1:0] st_b;
  logic [7:0] mem_b [0:255];
  int         wp_b, rp_b, wp_lag_b;

  assign empty_b = (wp_b == rp_b);
  assign dout_b  = mem_b[rp_b[7:0]];
  assign space_b = 9'(wp_lag_b - rp_b);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rp_b     <= 0;
      wp_lag_b <= 0;
    end else begin
      wp_lag_b <= wp_b;
      if (rd_en_b) rp_b <= rp_b + 1;
    end
  end

  fifo_burst_reader #(.DW(8), .AW(8), .BURST_LEN(1), .TIMEOUT(255)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .fifo_dout(dout_b), .fifo_empty(empty_b),
    .fifo_rd_space(space_b), .fifo_rd_en(rd_en_b), .m_data(data_b),
    .m_valid(m_valid_b), .m_ready(ready_b), .m_sof(sof_b), .m_eof(eof_b),
    .m_len(len_b), .frame_cnt(fcnt_b), .busy(busy_b), .dbg_state(st_b)
  );

  // ---------------- dut_c, constant inputs ----------------
  logic       en_c, ready_c, rd_en_c, empty_c;
  logic       m_valid_c, sof_c, eof_c, busy_c;
  logic [7:0] dout_c, data_c;
  logic [8:0] space_c, len_c;
  logic [15:0] fcnt_c;
  logic [1:0] st_c;

  fifo_burst_reader #(.DW(8), .AW(8), .BURST_LEN(4), .TIMEOUT(0)) dut_c (
    .clk(clk), .rst(rst), .en(en_c), .fifo_dout(dout_c), .fifo_empty(empty_c),
    .fifo_rd_space(space_c), .fifo_rd_en(rd_en_c), .m_data(data_c),
    .m_valid(m_valid_c), .m_ready(ready_c), .m_sof(sof_c), .m_eof(eof_c),
    .m_len(len_c), .frame_cnt(fcnt_c), .busy(busy_c), .dbg_state(st_c)
  );

  // ---------------- collected beats of dut_a ----------------
  logic [7:0] got_data [$];
  logic       got_sof  [$];
  logic       got_eof  [$];
  logic [8:0] got_len  [$];
  int         got_cyc  [$];
  int         viol_hold, viol_rd_en, viol_stall;

  task automatic push_a(input logic [7:0] v);
    mem_a[wp_a[7:0]] = v;
    wp_a = wp_a + 1;
  endtask

  task automatic push_b(input logic [7:0] v);
    mem_b[wp_b[7:0]] = v;
    wp_b = wp_b + 1;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic step_a(input logic rdy, input logic hold);
    @(negedge clk);
    ready_a = rdy;
    hold_a  = hold;
    #1;
  endtask

  // Runs dut_a until n_beats are accepted or budget cycles pass. Optionally
  // toggles m_ready each cycle, and holds the FIFO empty for stall_len cycles
  // once stall_at pops have been issued.
  task automatic run_a(input int n_beats, input int budget, input bit toggle,
                       input int stall_at, input int stall_len);
    logic       rdy, hold;
    bit         prev_stall;
    logic [7:0] prev_data;
    logic       prev_sof, prev_eof;
    int         pops, held;
    got_data.delete(); got_sof.delete(); got_eof.delete();
    got_len.delete();  got_cyc.delete();
    viol_hold = 0; viol_rd_en = 0; viol_stall = 0;
    rdy = 1'b1; prev_stall = 1'b0; prev_data = '0; prev_sof = 1'b0;
    prev_eof = 1'b0; pops = 0; held = 0;
    for (int cyc = 0; cyc < budget && got_data.size() < n_beats; cyc++) begin
      hold = (pops == stall_at) && (held < stall_len);
      if (hold) held++;
      step_a(rdy, hold);
      if (prev_stall && (!m_valid_a || data_a !== prev_data ||
                         sof_a !== prev_sof || eof_a !== prev_eof)) viol_hold++;
      if (rd_en_a && m_valid_a && !ready_a) viol_rd_en++;
      if (hold && (rd_en_a || !busy_a)) viol_stall++;
      if (rd_en_a) pops++;
      if (m_valid_a && ready_a) begin
        got_data.push_back(data_a);
        got_sof.push_back(sof_a);
        got_eof.push_back(eof_a);
        got_len.push_back(len_a);
        got_cyc.push_back(cyc);
      end
      prev_stall = m_valid_a && !ready_a;
      prev_data  = data_a;
      prev_sof   = sof_a;
      prev_eof   = eof_a;
      if (toggle) rdy = ~rdy;
    end
    hold_a = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b0;
    #2 rst = 1'b1;
    step_a(1'b1, 1'b0);
    step_a(1'b1, 1'b0);
    tests_run++;
    if ({m_valid_a, sof_a, eof_a, busy_a, rd_en_a} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_flags_a: got %b expected 00000",
               {m_valid_a, sof_a, eof_a, busy_a, rd_en_a});
    end
    tests_run++;
    if (data_a !== 8'h00 || len_a !== 9'd0 || fcnt_a !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_regs_a: got data=%h len=%0d fcnt=%h expected 00/0/0000",
               data_a, len_a, fcnt_a);
    end
    tests_run++;
    if (st_a !== 2'd0 || busy_b !== 1'b0 || busy_c !== 1'b0 || fcnt_b !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_state: got st_a=%0d busy_b=%b busy_c=%b fcnt_b=%h expected 0/0/0/0000",
               st_a, busy_b, busy_c, fcnt_b);
    end
    rst = 1'b0;
  endtask

  task automatic test_full_burst;
    en_a = 1'b0;
    step_a(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) push_a(8'h10 + 8'(i));
    step_a(1'b1, 1'b0);
    step_a(1'b1, 1'b0);
    en_a = 1'b1;
    run_a(4, 40, 1'b0, -1, 0);
    tests_run++;
    if (got_data.size() != 4) begin
      tests_failed++;
      $display("FAIL full_count: got %0d beats expected 4", got_data.size());
    end
    for (int k = 0; k < got_data.size(); k++) begin
      tests_run++;
      if (got_data[k] !== 8'h10 + 8'(k) || got_sof[k] !== (k == 0) ||
          got_eof[k] !== (k == 3) || got_len[k] !== 9'd4 || got_cyc[k] != got_cyc[0] + k) begin
        tests_failed++;
        $display("FAIL full_beat%0d: got data=%h sof=%b eof=%b len=%0d cyc=%0d expected %h/%b/%b/4/%0d",
                 k, got_data[k], got_sof[k], got_eof[k], got_len[k], got_cyc[k],
                 8'h10 + 8'(k), (k == 0), (k == 3), got_cyc[0] + k);
      end
    end
    en_a = 1'b0;
    step_a(1'b1, 1'b0);
    tests_run++;
    if (fcnt_a !== 16'd1 || busy_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_frame_cnt: got fcnt=%0d busy=%b expected 1/0", fcnt_a, busy_a);
    end
  endtask

  task automatic test_backpressure;
    en_a = 1'b0;
    for (int i = 0; i < 4; i++) push_a(8'h20 + 8'(i));
    step_a(1'b1, 1'b0);
    step_a(1'b1, 1'b0);
    en_a = 1'b1;
    run_a(4, 60, 1'b1, -1, 0);
    tests_run++;
    if (got_data.size() != 4) begin
      tests_failed++;
      $display("FAIL bp_count: got %0d beats expected 4", got_data.size());
    end
    for (int k = 0; k < got_data.size(); k++) begin
      tests_run++;
      if (got_data[k] !== 8'h20 + 8'(k) || got_sof[k] !== (k == 0) ||
          got_eof[k] !== (k == 3) || got_len[k] !== 9'd4) begin
        tests_failed++;
        $display("FAIL bp_beat%0d: got data=%h sof=%b eof=%b len=%0d expected %h/%b/%b/4",
                 k, got_data[k], got_sof[k], got_eof[k], got_len[k],
                 8'h20 + 8'(k), (k == 0), (k == 3));
      end
    end
    tests_run++;
    if (viol_rd_en != 0 || viol_hold != 0) begin
      tests_failed++;
      $display("FAIL bp_hold: got rd_en_under_stall=%0d hold_breaks=%0d expected 0/0",
               viol_rd_en, viol_hold);
    end
    en_a = 1'b0;
    step_a(1'b1, 1'b0);
    tests_run++;
    if (fcnt_a !== 16'd2) begin
      tests_failed++;
      $display("FAIL bp_frame_cnt: got %0d expected 2", fcnt_a);
    end
  endtask

  task automatic test_timeout;
    bit early;
    en_a = 1'b1;
    step_a(1'b1, 1'b0);
    step_a(1'b1, 1'b0);
    push_a(8'h30);
    push_a(8'h31);
    early = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step_a(1'b1, 1'b0);
      if (busy_a !== 1'b0) early = 1'b1;
    end
    tests_run++;
    if (early) begin
      tests_failed++;
      $display("FAIL timeout_early: got busy within 5 idle cycles expected idle");
    end
    step_a(1'b1, 1'b0);
    tests_run++;
    if (busy_a !== 1'b1 || len_a !== 9'd2) begin
      tests_failed++;
      $display("FAIL timeout_start: got busy=%b len=%0d expected 1/2", busy_a, len_a);
    end
    run_a(2, 20, 1'b0, -1, 0);
    tests_run++;
    if (got_data.size() != 2) begin
      tests_failed++;
      $display("FAIL timeout_count: got %0d beats expected 2", got_data.size());
    end
    for (int k = 0; k < got_data.size(); k++) begin
      tests_run++;
      if (got_data[k] !== 8'h30 + 8'(k) || got_sof[k] !== (k == 0) ||
          got_eof[k] !== (k == 1) || got_len[k] !== 9'd2) begin
        tests_failed++;
        $display("FAIL timeout_beat%0d: got data=%h sof=%b eof=%b len=%0d expected %h/%b/%b/2",
                 k, got_data[k], got_sof[k], got_eof[k], got_len[k],
                 8'h30 + 8'(k), (k == 0), (k == 1));
      end
    end
    step_a(1'b1, 1'b0);
    tests_run++;
    if (fcnt_a !== 16'd3) begin
      tests_failed++;
      $display("FAIL timeout_frame_cnt: got %0d expected 3", fcnt_a);
    end
  endtask

  task automatic test_stall;
    en_a = 1'b1;
    step_a(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) push_a(8'h40 + 8'(i));
    run_a(4, 60, 1'b0, 2, 6);
    tests_run++;
    if (got_data.size() != 4) begin
      tests_failed++;
      $display("FAIL stall_count: got %0d beats expected 4", got_data.size());
    end
    for (int k = 0; k < got_data.size(); k++) begin
      tests_run++;
      if (got_data[k] !== 8'h40 + 8'(k) || got_sof[k] !== (k == 0) ||
          got_eof[k] !== (k == 3) || got_len[k] !== 9'd4) begin
        tests_failed++;
        $display("FAIL stall_beat%0d: got data=%h sof=%b eof=%b len=%0d expected %h/%b/%b/4",
                 k, got_data[k], got_sof[k], got_eof[k], got_len[k],
                 8'h40 + 8'(k), (k == 0), (k == 3));
      end
    end
    tests_run++;
    if (viol_stall != 0) begin
      tests_failed++;
      $display("FAIL stall_hold: got %0d pop-or-abort cycles while empty expected 0", viol_stall);
    end
    step_a(1'b1, 1'b0);
    tests_run++;
    if (fcnt_a !== 16'd4) begin
      tests_failed++;
      $display("FAIL stall_frame_cnt: got %0d expected 4", fcnt_a);
    end
  endtask

  task automatic test_reset_mid;
    en_a = 1'b1;
    step_a(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) push_a(8'h50 + 8'(i));
    run_a(2, 40, 1'b0, -1, 0);
    tests_run++;
    if (got_data.size() != 2 || got_eof[0] !== 1'b0 || got_eof[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_pre: got %0d beats (eof seen) expected 2 beats without eof",
               got_data.size());
    end
    rst  = 1'b1;
    wp_a = 0;
    wp_b = 0;
    #1;
    tests_run++;
    if ({m_valid_a, sof_a, eof_a, busy_a, rd_en_a} !== 5'b0 || data_a !== 8'h00 ||
        len_a !== 9'd0 || fcnt_a !== 16'h0000) begin
      tests_failed++;
      $display("FAIL rstmid_values: got flags=%b data=%h len=%0d fcnt=%h expected 00000/00/0/0000",
               {m_valid_a, sof_a, eof_a, busy_a, rd_en_a}, data_a, len_a, fcnt_a);
    end
    step_a(1'b1, 1'b0);
    tests_run++;
    if (rd_en_a !== 1'b0 || eof_a !== 1'b0 || busy_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_held: got rd_en=%b eof=%b busy=%b expected 0/0/0",
               rd_en_a, eof_a, busy_a);
    end
    rst = 1'b0;
    step_a(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) push_a(8'h60 + 8'(i));
    run_a(4, 40, 1'b0, -1, 0);
    tests_run++;
    if (got_data.size() != 4 || got_data[0] !== 8'h60 || got_sof[0] !== 1'b1 ||
        got_eof[3] !== 1'b1 || got_data[3] !== 8'h63) begin
      tests_failed++;
      $display("FAIL rstmid_restart: got %0d beats first=%h expected 4 beats 60..63 framed",
               got_data.size(), got_data[0]);
    end
    step_a(1'b1, 1'b0);
    tests_run++;
    if (fcnt_a !== 16'd1) begin
      tests_failed++;
      $display("FAIL rstmid_frame_cnt: got %0d expected 1", fcnt_a);
    end
  endtask

  task automatic test_timeout_off;
    int bad;
    dout_c  = 8'hAA;
    space_c = 9'd2;
    empty_c = 1'b0;
    ready_c = 1'b1;
    en_c    = 1'b1;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (busy_c || rd_en_c || m_valid_c) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL timeout_off: got %0d active cycles expected 0", bad);
    end
    en_c = 1'b0;
  endtask

  task automatic test_len1;
    logic [15:0] exp_f;
    int beats;
    en_b    = 1'b0;
    ready_b = 1'b1;
    @(negedge clk);
    force dut_b.frame_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut_b.frame_cnt_q;
    #1;
    for (int i = 0; i < 3; i++) push_b(8'h70 + 8'(i));
    en_b  = 1'b1;
    beats = 0;
    for (int cyc = 0; cyc < 60 && beats < 3; cyc++) begin
      @(negedge clk);
      #1;
      if (m_valid_b) begin
        exp_f = 16'hFFFE + 16'(beats);
        tests_run++;
        if (data_b !== 8'h70 + 8'(beats) || sof_b !== 1'b1 || eof_b !== 1'b1 ||
            len_b !== 9'd1 || fcnt_b !== exp_f) begin
          tests_failed++;
          $display("FAIL len1_beat%0d: got data=%h sof=%b eof=%b len=%0d fcnt=%h expected %h/1/1/1/%h",
                   beats, data_b, sof_b, eof_b, len_b, fcnt_b, 8'h70 + 8'(beats), exp_f);
        end
        beats++;
      end
    end
    tests_run++;
    if (beats != 3) begin
      tests_failed++;
      $display("FAIL len1_count: got %0d beats expected 3", beats);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (fcnt_b !== 16'h0001) begin
      tests_failed++;
      $display("FAIL len1_wrap: got fcnt=%h expected 0001", fcnt_b);
    end
    en_b = 1'b0;
  endtask

  initial begin
    en_a = 1'b0; ready_a = 1'b1; hold_a = 1'b0; wp_a = 0;
    en_b = 1'b0; ready_b = 1'b1; wp_b = 0;
    en_c = 1'b0; ready_c = 1'b1; empty_c = 1'b1; space_c = '0; dout_c = '0;
    test_reset();
    test_full_burst();
    test_backpressure();
    test_timeout();
    test_stall();
    test_reset_mid();
    test_timeout_off();
    test_len1();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 SHALL have parameter DW, default 8: data width in bits, matching the upstream FWFT FIFO.
REQ-002 SHALL have parameter AW, default 8: FIFO address width; the FIFO fill level is AW+1 bits wide.
REQ-003 SHALL have parameter BURST_LEN, default 16: full burst length in beats, legal range 1..2**AW; an out-of-range value stops elaboration with a message.
REQ-004 SHALL have parameter TIMEOUT, default 255: idle cycles before a partial burst is flushed; 0 disables partial flush.
REQ-005 SHALL have port clk, input, 1 bit: clock; all logic is on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port en, input, 1 bit: enables the start of new bursts.
REQ-008 SHALL have port fifo_dout, input, DW bits: FWFT head word from the FIFO.
REQ-009 SHALL have port fifo_empty, input, 1 bit: FIFO empty flag.
REQ-010 SHALL have port fifo_rd_space, input, AW+1 bits: FIFO fill level (registered and lagging, never overstated).
REQ-011 SHALL have port fifo_rd_en, output, 1 bit: FIFO pop, combinational.
REQ-012 SHALL have port m_data, output, DW bits: output beat data, registered.
REQ-013 SHALL have port m_valid, output, 1 bit: output beat valid.
REQ-014 SHALL have port m_ready, input, 1 bit: downstream accept.
REQ-015 SHALL have port m_sof, output, 1 bit: first beat of a burst.
REQ-016 SHALL have port m_eof, output, 1 bit: last beat of a burst.
REQ-017 SHALL have port m_len, output, AW+1 bits: length of the current burst, stable from the first beat through the last.
REQ-018 SHALL have port frame_cnt, output, 16 bits: count of completed bursts, wraps modulo 2**16.
REQ-019 SHALL have port busy, output, 1 bit: high when the state is not IDLE.

Function
REQ-020 SHALL implement exactly three states: IDLE, BURST, DRAIN.
REQ-021 In IDLE with en=1 and fifo_rd_space>=BURST_LEN, SHALL latch m_len=BURST_LEN, load remaining=BURST_LEN, and go to BURST.
REQ-022 In IDLE with en=1, fifo_empty=0 and fifo_rd_space<BURST_LEN, SHALL increment a 16-bit idle counter each cycle; when TIMEOUT!=0 and the counter equals TIMEOUT, SHALL latch m_len=remaining=fifo_rd_space and go to BURST, but only if fifo_rd_space>0 (otherwise hold).
REQ-023 The idle counter SHALL clear whenever fifo_empty=1, en=0, or the state leaves IDLE.
REQ-024 SHALL drive fifo_rd_en = (state==BURST) & (remaining!=0) & ~fifo_empty & (~m_valid | m_ready).
REQ-025 On fifo_rd_en, SHALL register m_data<=fifo_dout and m_valid<=1 (one-cycle latency), and decrement remaining.
REQ-026 If m_valid & m_ready with no fifo_rd_en in the same cycle, SHALL clear m_valid; m_data, m_sof, m_eof and m_valid SHALL hold while m_valid & ~m_ready.
REQ-027 SHALL assert m_sof on the beat popped when remaining==m_len, and m_eof on the beat popped when remaining==1; when m_len==1 both SHALL assert on the same beat.
REQ-028 When the last beat is popped (remaining 1->0), SHALL move BURST->DRAIN; in DRAIN, on m_valid & m_ready, SHALL clear m_valid, increment frame_cnt, and go to IDLE.
REQ-029 While fifo_empty=1 in BURST, SHALL stall with no pop, no timeout, and no abort.
REQ-030 Deassertion of en SHALL NOT abort an in-progress burst; it only blocks IDLE->BURST.
REQ-031 remaining, m_len and the space comparisons SHALL be AW+1 bits wide and unsigned.

Reset
REQ-032 On rst=1: state=IDLE, m_valid=0, m_sof=0, m_eof=0, m_data=0, m_len=0, frame_cnt=0, idle counter=0, remaining=0, busy=0; fifo_rd_en SHALL be 0 during reset.
REQ-033 Reset asserted mid-burst SHALL discard the partial burst with no m_eof generated; after release the block SHALL restart from IDLE.

Verification
REQ-034 BURST_LEN=4, FIFO preloaded with 0x10..0x13, m_ready=1 -> 4 consecutive beats 0x10..0x13, sof on 0x10, eof on 0x13, m_len=4, frame_cnt=1.
REQ-035 Same setup with m_ready toggling 1,0,1,0 -> no beat lost or duplicated; m_data holds while m_ready=0; fifo_rd_en never high while m_valid & ~m_ready.
REQ-036 TIMEOUT=5, 2 words written then idle -> burst starts after the counter reaches 5, m_len=2, sof+eof correctly placed; TIMEOUT=0 -> no burst ever.
REQ-037 BURST_LEN=1 -> every beat carries both m_sof and m_eof; frame_cnt increments per beat; frame_cnt wraps 0xFFFF->0x0000.
REQ-038 Burst in progress, FIFO runs empty after 2 of 4 beats -> stall, then resume on refill with eof on the 4th beat; rst pulsed at beat 2 of a second burst -> outputs return to reset values, no eof.
